// File: rtl/tankb_video_pkg.sv
// Shared geometry defaults, widths and types for the Tank Battalion video receiver.
package tankb_video_pkg;

    localparam int unsigned H_TOTAL_DEF     = 384;
    localparam int unsigned V_HS_EXPECT_DEF = 256;
    localparam int unsigned VS_MIN_DEF      = 512;

    localparam int unsigned X_START_DEF     = 64;
    localparam int unsigned Y_START_DEF     = 16;
    localparam int unsigned X_WIDTH_DEF     = 256;
    localparam int unsigned Y_HEIGHT_DEF    = 224;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam int unsigned RUN_W  = 12;
    localparam int unsigned X_W    = 12;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned REL_W  = 8;
    localparam int unsigned ADDR_W = 2 * REL_W;
    localparam int unsigned RGB_W  = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RGB_W-1:0]  data;
    } wr_pix_t;

endpackage

// File: rtl/tankb_video_rx_if.sv
// Video input and capture/status outputs of the receiver, bundled for port use.
interface tankb_video_rx_if;
    import tankb_video_pkg::*;

    logic              pix_en;
    logic              csync_n;
    logic              red;
    logic              green;
    logic              blue;
    logic              hs_evt;
    logic              vs_evt;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              locked;
    logic              len_err;
    logic              frame_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [RGB_W-1:0]  wr_data;

    modport master (
        output pix_en, csync_n, red, green, blue,
        input  hs_evt, vs_evt, x, y, locked, len_err, frame_err, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pix_en, csync_n, red, green, blue,
        output hs_evt, vs_evt, x, y, locked, len_err, frame_err, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/tankb_csync_sep.sv
// Composite sync separator: measures each csync low run and classifies its release
// as HSYNC or VSYNC. Event outputs are combinational for the sample being taken.
module tankb_csync_sep
    import tankb_video_pkg::*;
#(
    parameter int unsigned VS_MIN = VS_MIN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en_i,
    input  logic csync_n_i,
    output logic hs_evt_c_o,
    output logic vs_evt_c_o
);

    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] VS_MIN_R = RUN_W'(VS_MIN);

    logic [RUN_W-1:0] run_q, run_d;
    logic             low_q, low_d;

    always_comb begin
        run_d      = run_q;
        low_d      = low_q;
        hs_evt_c_o = 1'b0;
        vs_evt_c_o = 1'b0;
        if (pix_en_i) begin
            low_d = ~csync_n_i;
            if (!csync_n_i) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
                // A saturated run still compares >= VS_MIN, so it releases as VSYNC.
                if (low_q) begin
                    hs_evt_c_o = (run_q < VS_MIN_R);
                    vs_evt_c_o = (run_q >= VS_MIN_R);
                end
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= '0;
            low_q <= 1'b0;
        end else begin
            run_q <= run_d;
            low_q <= low_d;
        end
    end

endmodule

// File: rtl/tankb_video_rx.sv
// Tank Battalion video receiver: beam X/Y recovery, line/frame geometry checks,
// lock state machine and windowed pixel capture into an external frame store.
module tankb_video_rx
    import tankb_video_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned V_HS_EXPECT = V_HS_EXPECT_DEF,
    parameter int unsigned VS_MIN      = VS_MIN_DEF,
    parameter int unsigned X_START     = X_START_DEF,
    parameter int unsigned Y_START     = Y_START_DEF,
    parameter int unsigned X_WIDTH     = X_WIDTH_DEF,
    parameter int unsigned Y_HEIGHT    = Y_HEIGHT_DEF,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input logic            clk,
    input logic            reset,
    tankb_video_rx_if.slave bus
);

    localparam int unsigned LL_W = X_W + 1;
    localparam int unsigned GC_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [LL_W-1:0] LINE_LEN = LL_W'(H_TOTAL);
    localparam logic [Y_W-1:0]  Y_EXPECT = Y_W'(V_HS_EXPECT);
    localparam logic [X_W-1:0]  X_LO     = X_W'(X_START);
    localparam logic [X_W-1:0]  X_HI     = X_W'(X_START + X_WIDTH);
    localparam logic [Y_W-1:0]  Y_LO     = Y_W'(Y_START);
    localparam logic [Y_W-1:0]  Y_HI     = Y_W'(Y_START + Y_HEIGHT);
    localparam logic [X_W-1:0]  X_MAX    = '1;
    localparam logic [Y_W-1:0]  Y_MAX    = '1;
    localparam logic [GC_W-1:0] GC_LAST  = GC_W'(LOCK_FRAMES - 1);

    logic hs_c, vs_c;

    tankb_csync_sep #(
        .VS_MIN (VS_MIN)
    ) u_sep (
        .clk        (clk),
        .reset      (reset),
        .pix_en_i   (bus.pix_en),
        .csync_n_i  (bus.csync_n),
        .hs_evt_c_o (hs_c),
        .vs_evt_c_o (vs_c)
    );

    rx_state_t       state_q;
    logic [GC_W-1:0] good_cnt_q;
    logic            locked_q;

    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            first_line_q, first_line_d;
    logic            len_seen_q, len_seen_d;
    logic            hs_evt_q, hs_evt_d;
    logic            vs_evt_q, vs_evt_d;
    logic            len_err_q, len_err_d;
    logic            frame_err_q, frame_err_d;
    logic            wr_en_q, wr_en_d;
    wr_pix_t         wr_pix_q, wr_pix_d;
    logic            good_frame;
    logic [LL_W-1:0] line_len;
    logic [REL_W-1:0] x_rel, y_rel;

    // Counters, geometry checks and capture decode for the current sample.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        first_line_d = first_line_q;
        len_seen_d   = len_seen_q;
        hs_evt_d     = 1'b0;
        vs_evt_d     = 1'b0;
        len_err_d    = 1'b0;
        frame_err_d  = 1'b0;
        good_frame   = 1'b0;
        wr_en_d      = 1'b0;
        wr_pix_d     = '0;
        line_len     = LL_W'(x_q) + LL_W'(1);
        x_rel        = '0;
        y_rel        = '0;
        if (bus.pix_en) begin
            if (vs_c) begin
                vs_evt_d     = 1'b1;
                x_d          = '0;
                y_d          = '0;
                frame_err_d  = (y_q != Y_EXPECT);
                good_frame   = (y_q == Y_EXPECT) && !len_seen_q;
                first_line_d = 1'b1;
                len_seen_d   = 1'b0;
            end else if (hs_c) begin
                // The line that follows VSYNC starts at an arbitrary phase; skip its length.
                hs_evt_d     = 1'b1;
                x_d          = '0;
                y_d          = (y_q == Y_MAX) ? y_q : y_q + Y_W'(1);
                len_err_d    = !first_line_q && (line_len != LINE_LEN);
                len_seen_d   = len_seen_q || len_err_d;
                first_line_d = 1'b0;
            end else begin
                x_d   = (x_q == X_MAX) ? x_q : x_q + X_W'(1);
                x_rel = REL_W'(x_d - X_LO);
                y_rel = REL_W'(y_q - Y_LO);
                if ((state_q == LOCKED) && (x_d >= X_LO) && (x_d < X_HI) &&
                    (y_q >= Y_LO) && (y_q < Y_HI)) begin
                    wr_en_d       = 1'b1;
                    wr_pix_d.addr = {y_rel, x_rel};
                    wr_pix_d.data = {bus.red, bus.green, bus.blue};
                end
            end
        end
    end

    // Lock state machine; an error on the same sample as a lock-qualifying frame wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    if (vs_evt_d) begin
                        state_q    <= ACQUIRE;
                        good_cnt_q <= '0;
                    end
                end
                ACQUIRE: begin
                    if (len_err_d || frame_err_d) begin
                        state_q <= UNLOCKED;
                    end else if (good_frame) begin
                        if (good_cnt_q == GC_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            good_cnt_q <= good_cnt_q + GC_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (len_err_d || frame_err_d) begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            first_line_q <= 1'b0;
            len_seen_q   <= 1'b0;
            hs_evt_q     <= 1'b0;
            vs_evt_q     <= 1'b0;
            len_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_pix_q     <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            first_line_q <= first_line_d;
            len_seen_q   <= len_seen_d;
            hs_evt_q     <= hs_evt_d;
            vs_evt_q     <= vs_evt_d;
            len_err_q    <= len_err_d;
            frame_err_q  <= frame_err_d;
            wr_en_q      <= wr_en_d;
            wr_pix_q     <= wr_pix_d;
        end
    end

    assign bus.hs_evt    = hs_evt_q;
    assign bus.vs_evt    = vs_evt_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.locked    = locked_q;
    assign bus.len_err   = len_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_pix_q.addr;
    assign bus.wr_data   = wr_pix_q.data;

endmodule

// File: tb/tb_tankb_video_rx.sv
// Directed bench for tankb_video_rx on a reduced geometry (96-pixel lines, 12 HSYNCs
// per frame, 64x8 capture window at x=16, y=2) with the full 512-pixel VSYNC threshold.
module tb_tankb_video_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tankb_video_rx_if bus ();

    tankb_video_rx #(
        .H_TOTAL     (96),
        .V_HS_EXPECT (12),
        .VS_MIN      (512),
        .X_START     (16),
        .Y_START     (2),
        .X_WIDTH     (64),
        .Y_HEIGHT    (8),
        .LOCK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int n_hs, n_vs, n_len, n_fe, n_wr;
    logic vs_locked, vs_prev_locked, len_locked, prev_locked;
    logic [15:0] first_addr, last_addr;
    logic [2:0]  first_data, last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clr();
        n_hs = 0; n_vs = 0; n_len = 0; n_fe = 0; n_wr = 0;
        vs_locked = 1'b0; vs_prev_locked = 1'b0; len_locked = 1'b0;
        first_addr = '0; last_addr = '0; first_data = '0; last_data = '0;
    endtask

    task automatic sample();
        if (bus.hs_evt) n_hs++;
        if (bus.vs_evt) begin
            n_vs++;
            vs_locked      = bus.locked;
            vs_prev_locked = prev_locked;
        end
        if (bus.len_err) begin
            n_len++;
            len_locked = bus.locked;
        end
        if (bus.frame_err) n_fe++;
        if (bus.wr_en) begin
            if (n_wr == 0) begin
                first_addr = bus.wr_addr;
                first_data = bus.wr_data;
            end
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            n_wr++;
        end
        prev_locked = bus.locked;
    endtask

    task automatic px(input logic cs, input logic [2:0] rgb);
        bus.csync_n = cs;
        {bus.red, bus.green, bus.blue} = rgb;
        bus.pix_en = 1'b1;
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic hold(input logic cs);
        bus.csync_n = cs;
        bus.pix_en  = 1'b0;
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic run(input logic cs, input int n);
        for (int i = 0; i < n; i++) px(cs, 3'b000);
    endtask

    // Lines of 96 pixels whose last 8 are the HSYNC low; optional 600-pixel VSYNC after.
    task automatic frame(input int short_line, input int nlines, input bit with_vs);
        int len;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? 95 : 96;
            for (int p = 0; p < len; p++) px((p >= len - 8) ? 1'b0 : 1'b1, 3'(p + l + 3));
        end
        if (with_vs) run(1'b0, 600);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_flags"}, {26'd0, bus.hs_evt, bus.vs_evt, bus.len_err,
                                bus.frame_err, bus.wr_en, bus.locked}, 32'd0);
        check({tag, "_x"}, 32'(bus.x), 32'd0);
        check({tag, "_y"}, 32'(bus.y), 32'd0);
        check({tag, "_wr"}, {13'd0, bus.wr_addr, bus.wr_data}, 32'd0);
    endtask

    initial begin
        bus.pix_en = 1'b0; bus.csync_n = 1'b1;
        bus.red = 1'b0; bus.green = 1'b0; bus.blue = 1'b0;
        prev_locked = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        clr();
        repeat (3) hold(1'b0);
        check("pix_en_low_x", 32'(bus.x), 32'd0);
        run(1'b1, 20);
        check("idle_x", 32'(bus.x), 32'd20);
        check("idle_events", 32'(n_hs + n_vs), 32'd0);

        run(1'b0, 600);
        clr();
        frame(-1, 13, 1'b1);
        check("f1_vs", 32'(n_vs), 32'd1);
        check("f1_hs", 32'(n_hs), 32'd12);
        check("f1_frame_err", 32'(n_fe), 32'd1);
        check("f1_locked", 32'(vs_locked), 32'd0);

        clr();
        frame(-1, 13, 1'b1);
        check("f2_frame_err", 32'(n_fe), 32'd0);
        check("f2_locked", 32'(vs_locked), 32'd0);

        clr();
        frame(-1, 13, 1'b1);
        check("f3_locked_at_vs", 32'(vs_locked), 32'd1);
        check("f3_unlocked_before_vs", 32'(vs_prev_locked), 32'd0);
        check("f3_writes", 32'(n_wr), 32'd512);
        check("f3_first_addr", 32'(first_addr), 32'h0000);
        check("f3_first_data", 32'(first_data), 32'd5);
        check("f3_last_addr", 32'(last_addr), 32'h073F);
        check("f3_last_data", 32'(last_data), 32'd3);
        check("f3_errors", 32'(n_len + n_fe), 32'd0);

        clr();
        frame(5, 13, 1'b1);
        check("f4_locked_at_vs", 32'(vs_locked), 32'd1);
        check("f4_len_err", 32'(n_len), 32'd1);
        check("f4_locked_at_len_err", 32'(len_locked), 32'd0);
        check("f4_writes", 32'(n_wr), 32'd256);

        clr();
        frame(-1, 13, 1'b1);
        frame(-1, 13, 1'b1);
        check("f56_writes", 32'(n_wr), 32'd0);
        check("f56_locked", 32'(vs_locked), 32'd0);

        clr();
        frame(-1, 7, 1'b0);
        check("f7_relocked", 32'(vs_locked), 32'd1);
        check("f7_y", 32'(bus.y), 32'd6);
        check("f7_locked_mid", 32'(bus.locked), 32'd1);
        check("f7_writes", 32'(n_wr), 32'd320);

        bus.pix_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("mid_reset");
        reset = 1'b0;
        run(1'b1, 10);

        run(1'b0, 600);
        clr();
        frame(-1, 13, 1'b1);
        frame(-1, 13, 1'b1);
        check("reacq_vs", 32'(n_vs), 32'd2);
        check("reacq_writes", 32'(n_wr), 32'd0);
        check("reacq_locked", 32'(vs_locked), 32'd0);
        clr();
        frame(-1, 1, 1'b0);
        check("reacq_lock_at_vs", 32'(vs_locked), 32'd1);

        run(1'b1, 4);
        clr();
        run(1'b0, 511);
        px(1'b1, 3'b000);
        check("low511_hs", 32'(n_hs), 32'd1);
        check("low511_vs", 32'(n_vs), 32'd0);

        run(1'b1, 4);
        clr();
        run(1'b0, 512);
        px(1'b1, 3'b000);
        check("low512_vs", 32'(n_vs), 32'd1);
        check("low512_hs", 32'(n_hs), 32'd0);

        run(1'b1, 4);
        run(1'b0, 8);
        px(1'b1, 3'b000);
        check("short_hs_y", 32'(bus.y), 32'd1);

        run(1'b1, 4);
        clr();
        run(1'b0, 5000);
        check("long_low_x_sat", 32'(bus.x), 32'd4095);
        px(1'b1, 3'b000);
        check("long_low_vs", 32'(n_vs), 32'd1);
        check("long_low_hs", 32'(n_hs), 32'd0);
        check("long_low_x", 32'(bus.x), 32'd0);
        check("long_low_y", 32'(bus.y), 32'd0);

        clr();
        repeat (5) hold(1'b0);
        check("hold_x", 32'(bus.x), 32'd0);
        px(1'b1, 3'b000);
        check("hold_resume_x", 32'(bus.x), 32'd1);
        check("hold_events", 32'(n_hs + n_vs), 32'd0);

        bus.pix_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
